// File: rtl/fsm_pulse_stretch_pkg.sv
// Shared definitions for the pulse-to-level regenerator.
// State encodings are fixed so that other blocks and debug tooling can decode them.
package fsm_pulse_stretch_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HIGH = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   localparam int unsigned CNT_W_DEFAULT = 8;

endpackage

// File: rtl/fsm_pulse_stretch_load_down_counter.sv
// Loadable down-counter with terminal-count flag.
// A load takes priority over a decrement, and the count holds at zero.
module load_down_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             zero
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/fsm_pulse_stretch.sv
// Pulse-to-level regenerator: single-cycle events become high windows of a programmable
// width, separated by a programmable low gap; busy events retrigger or queue one deep.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | waiting for an event, outputs low
//   S_HIGH | dout high, counter runs the window length
//   S_GAP  | dout low, counter enforces the minimum gap before a new window
module fsm_pulse_stretch
   import fsm_pulse_stretch_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic [CNT_W-1:0] width,
   input  logic [CNT_W-1:0] gap,
   input  logic             retrig,
   output logic             dout,
   output logic             busy,
   output logic             pend,
   output logic             drop
);

   state_t           state;
   state_t           state_next;
   logic             pend_next;
   logic             drop_next;
   logic             load;
   logic [CNT_W-1:0] load_val;
   logic             dec;
   logic [CNT_W-1:0] cnt;
   logic             zero;
   logic [CNT_W-1:0] width_reload;
   logic [CNT_W-1:0] gap_reload;
   logic             gap_zero;

   // A zero width still produces a one-cycle window.
   assign width_reload = (width == '0) ? '0 : (width - CNT_W'(1));
   assign gap_reload   = gap - CNT_W'(1);
   assign gap_zero     = (gap == '0);

   load_down_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .dec      (dec),
      .cnt      (cnt),
      .zero     (zero)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_IDLE;
         pend  <= 1'b0;
         drop  <= 1'b0;
      end else begin
         state <= state_next;
         pend  <= pend_next;
         drop  <= drop_next;
      end
   end

   always_comb begin
      state_next = state;
      pend_next  = pend;
      drop_next  = 1'b0;
      load       = 1'b0;
      load_val   = width_reload;
      dec        = 1'b0;

      case (state)
         S_IDLE: begin
            if (din) begin
               state_next = S_HIGH;
               load       = 1'b1;
            end
         end

         S_HIGH: begin
            dec = 1'b1;
            if (din && retrig) begin
               load = 1'b1;
            end else if (zero && gap_zero && (pend || din)) begin
               // Back-to-back window: consume the held event (or this one directly);
               // a fresh event behind a held one becomes the new held event.
               load      = 1'b1;
               pend_next = pend && din;
            end else begin
               if (din) begin
                  if (pend) begin
                     drop_next = 1'b1;
                  end else begin
                     pend_next = 1'b1;
                  end
               end
               if (zero) begin
                  if (!gap_zero) begin
                     state_next = S_GAP;
                     load       = 1'b1;
                     load_val   = gap_reload;
                  end else begin
                     state_next = S_IDLE;
                  end
               end
            end
         end

         S_GAP: begin
            dec = 1'b1;
            if (zero) begin
               if (pend || din) begin
                  state_next = S_HIGH;
                  load       = 1'b1;
                  pend_next  = pend && din;
               end else begin
                  state_next = S_IDLE;
               end
            end else if (din) begin
               if (pend) begin
                  drop_next = 1'b1;
               end else begin
                  pend_next = 1'b1;
               end
            end
         end

         default: begin
            state_next = S_IDLE;
            pend_next  = 1'b0;
         end
      endcase
   end

   assign dout = (state == S_HIGH);
   assign busy = (state != S_IDLE);

endmodule

// File: doc/fsm_pulse_stretch.md
# fsm_pulse_stretch

Pulse-to-level regenerator. It takes single-cycle event pulses, such as the output of the team's rising-edge detectors, and rebuilds a clean level waveform of programmable high width. A programmable minimum low gap separates consecutive windows. It sits downstream of an edge detector and drives strobes, LEDs or enables that need a level of known duration. Pulses arriving while busy are either retriggered (extend the window) or queued one deep, selectable at run time.

## Interface
- `CNT_W`, default 8: width of the `width`, `gap` and internal counter fields.
- `clk` in 1: clock. All logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `din` in 1: event pulse. Each high cycle is one event.
- `width` in CNT_W: high-window length in cycles. 0 is treated as 1.
- `gap` in CNT_W: minimum low cycles after a window. 0 means no gap.
- `retrig` in 1: 1 = extend the current window on an event; 0 = queue the event.
- `dout` out 1: regenerated level.
- `busy` out 1: state is not IDLE.
- `pend` out 1: one queued event is held.
- `drop` out 1: one-cycle pulse; an event was discarded.

## Operation
- States: IDLE, HIGH, GAP. `dout` = (state == HIGH), Moore-decoded from the state register. `busy` = (state != IDLE).
- Counter reload values:
  - On entry to HIGH, or on a retrigger: cnt loads max(width,1)-1.
  - On entry to GAP: cnt loads gap-1.
  - `width` and `gap` are sampled only at load time.
- **IDLE:** `din`=1 → HIGH with reload. Otherwise stay in IDLE.
- **HIGH:** cnt decrements each cycle.
  - `din`=1 and `retrig`=1: reload cnt and stay in HIGH. This takes priority over the cnt==0 exit.
  - `din`=1 and `retrig`=0: set `pend`. If `pend` is already set, pulse `drop` instead.
  - cnt==0 with no retrigger:
    - gap≠0 → GAP.
    - gap==0 and (`pend` or a queued `din`) → HIGH with reload, `pend` cleared. This gives a continuous high level.
    - Otherwise → IDLE.
- **GAP:** cnt decrements each cycle. `retrig` is ignored here.
  - `din`=1 sets `pend`, or pulses `drop` if `pend` is already set.
  - At cnt==0: (`pend` or `din`) → HIGH with reload, clear `pend`. Otherwise → IDLE.
- An event arriving in the same cycle that `pend` is consumed becomes the new `pend`.
- `drop` is registered and high for exactly one cycle per discarded event.
- Reset values: state=IDLE, cnt=0, `pend`=0, `drop`=0. Therefore `dout`=0 and `busy`=0.
- Reset applied mid-operation: all outputs are 0 on the next cycle and any queued event is lost.
- Illegal state encodings return to IDLE.

## Timing
- Latency: `din` in IDLE at cycle t → `dout` high on cycles t+1 … t+W, where W = max(width,1).
- After that window, `dout` stays low for at least G=gap cycles, and `busy` stays high through them.
- `busy` falls at cycle t+W+G+1 if nothing is queued.
- `pend` and `drop` update one cycle after the causing `din`.
- No combinational path from `din` to any output.

## Structure
- Shared package or include holds the state encodings: S_IDLE=2'd0, S_HIGH=2'd1, S_GAP=2'd2.
- The state register and next-state logic follow the team's two-process FSM style.
- One natural sub-module: `load_down_counter`. It is CNT_W wide, with `load`, `load_val`, `dec` inputs and `cnt` and `zero` outputs.

## Test plan
- **Single pulse.** width=3, gap=2, `din` at cycle 10 → `dout` high on cycles 11–13, `busy` high on 11–15, IDLE at 16.
- **Retrigger.** `retrig`=1, width=4, `din` at cycles 10 and 12 → `dout` high continuously on cycles 11–16; `pend` never set.
- **Queue.** `retrig`=0, width=3, gap=2, `din` at cycles 10 and 12 → `dout` high 11–13, low 14–15, high 16–18; `pend` high 13–15.
- **Drop.** Same as the queue case plus `din` at cycle 13 → `drop`=1 on cycle 14 only; exactly two high windows.
- **Zero settings.** width=0, gap=0, `retrig`=0, `din` at cycles 10 and 11 → `dout` high on cycles 11–12 with no low cycle between them; `busy` low at 13.
- **Reset mid-window.** width=5, `din` at cycle 10, plus a queued `din` at 12; `rst`=0 at cycle 13 → on cycle 14 `dout`=0, `busy`=0, `pend`=0, and no further window.
